cfs_dac_player: RTL and testbench

- Write-direction counterpart of the ADC capture path.
- Software pushes 14-bit DAC samples through CFS output bits: a data field plus a toggle strobe.
- The block buffers samples in an internal circular RAM and replays them to the DAC at a programmable sample period.
- It generates dac_clk_o itself and returns full/empty/level and sticky error status on CFS input bits. Single clock domain: the CPU clock.

---
 rtl/cfs_dac_player.sv | 206 ++++++++++++++++++++
 tb/tb_cfs_dac_player.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cfs_dac_player.sv
// cfs_dac_player: buffers 14-bit samples pushed over CFS toggle-strobe writes in a
// circular RAM and replays them to a DAC at a programmable sample period.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   wr_data_i, wr_tog_i     sample and toggle strobe (each edge of wr_tog_i = one write)
//   play_en_i, loop_i       playback enable, cyclic replay (1) vs FIFO consume (0)
//   clr_i                   synchronous clear
//   div_i                   sample period minus 1 (0 treated as 1)
//   dac_data_o, dac_clk_o   DAC sample and latch clock (DAC samples on rising edge)
//   full_o, empty_o, level_o  buffer status
//   underrun_o, overflow_o  sticky error flags
// Optional: define CFS_DAC_UNDERRUN_MIDSCALE_EN to drive IDLE_CODE on an underrun
// tick instead of holding the last sample.
module cfs_dac_player #(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned DIV_W      = 16,
  parameter logic [DATA_W-1:0] IDLE_CODE = DATA_W'(8192)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  wr_tog_i,
  input  logic                  play_en_i,
  input  logic                  loop_i,
  input  logic                  clr_i,
  input  logic [DIV_W-1:0]      div_i,
  output logic [DATA_W-1:0]     dac_data_o,
  output logic                  dac_clk_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  underrun_o,
  output logic                  overflow_o
);

  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, play_ptr_q, play_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                full_q, full_d, empty_q, empty_d;
  logic                tog_q, tog_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d, div_cur_q, div_cur_d;
  logic [DATA_W-1:0]   dac_data_q, dac_data_d;
  logic                dac_clk_q, dac_clk_d;
  logic                underrun_q, underrun_d, overflow_q, overflow_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rdata_q;

  logic                wr_evt_c, tick_c, pop_c, wr_acc_c, nonempty_c;
  logic [PTR_W-1:0]    raddr_c, play_nxt_c, rd_nxt_c;
  logic [DIV_W-1:0]    div_eff_c, half_c;

  assign nonempty_c = (level_q != '0);
  assign wr_evt_c   = (wr_tog_i != tog_q);
  assign tick_c     = (state_q == ST_RUN) && (cnt_q == '0) && play_en_i && !clr_i;
  assign pop_c      = tick_c && !loop_i && nonempty_c;
  assign wr_acc_c   = wr_evt_c && !clr_i && (!full_q || pop_c);
  // Loop mode walks play_ptr; FIFO mode always reads the head of the buffer.
  assign raddr_c    = loop_i ? play_ptr_q : rd_ptr_q;
  assign play_nxt_c = PTR_W'(play_ptr_q + 1'b1);
  assign rd_nxt_c   = PTR_W'(rd_ptr_q + 1'b1);
  assign div_eff_c  = (div_i == '0) ? DIV_W'(1) : div_i;
  assign half_c     = DIV_W'(((DIV_W+1)'(div_cur_q) + (DIV_W+1)'(1)) >> 1);

  // Sample RAM: synchronous read, write data forwarded when it targets the read address.
  always_ff @(posedge clk_i) begin
    if (wr_acc_c) mem[wr_ptr_q] <= wr_data_i;
    rdata_q <= (wr_acc_c && (wr_ptr_q == raddr_c)) ? wr_data_i : mem[raddr_c];
  end

  // Next-state: write side, playback FSM, divider and status.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    play_ptr_d = play_ptr_q;
    tog_d      = wr_tog_i;
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    dac_data_d = dac_data_q;
    dac_clk_d  = dac_clk_q;
    underrun_d = underrun_q;
    overflow_d = overflow_q;

    if (wr_acc_c) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
    if (wr_evt_c && full_q && !pop_c) overflow_d = 1'b1;
    level_d = LVL_W'(level_q + LVL_W'(wr_acc_c) - LVL_W'(pop_c));

    case (state_q)
      ST_IDLE: begin
        dac_clk_d = 1'b0;
        if (play_en_i && nonempty_c) begin
          state_d    = ST_PRIME;
          play_ptr_d = rd_ptr_q;
        end
      end
      ST_PRIME: begin
        state_d   = ST_RUN;
        cnt_d     = '0;
        div_cur_d = div_eff_c;
      end
      ST_RUN: begin
        if (cnt_q == div_cur_q) begin
          cnt_d     = '0;
          div_cur_d = div_eff_c;
        end else begin
          cnt_d = DIV_W'(cnt_q + 1'b1);
        end
        if (cnt_q == half_c) dac_clk_d = 1'b1;
        if (tick_c) begin
          dac_clk_d = 1'b0;
          if (loop_i) begin
            if (nonempty_c) begin
              dac_data_d = rdata_q;
              play_ptr_d = (play_nxt_c == wr_ptr_q) ? rd_ptr_q : play_nxt_c;
            end
          end else if (nonempty_c) begin
            dac_data_d = rdata_q;
            rd_ptr_d   = rd_nxt_c;
            play_ptr_d = rd_nxt_c;
          end else begin
            underrun_d = 1'b1;
            play_ptr_d = rd_ptr_q;
`ifdef CFS_DAC_UNDERRUN_MIDSCALE_EN
            dac_data_d = IDLE_CODE;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!play_en_i) begin
      state_d   = ST_IDLE;
      dac_clk_d = 1'b0;
    end

    // Clear wins over any write or tick; the shadow absorbs the current strobe level.
    if (clr_i) begin
      state_d    = ST_IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      play_ptr_d = '0;
      level_d    = '0;
      cnt_d      = '0;
      div_cur_d  = '0;
      dac_data_d = IDLE_CODE;
      dac_clk_d  = 1'b0;
      underrun_d = 1'b0;
      overflow_d = 1'b0;
    end

    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      play_ptr_q <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      tog_q      <= 1'b0;
      cnt_q      <= '0;
      div_cur_q  <= '0;
      dac_data_q <= IDLE_CODE;
      dac_clk_q  <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      play_ptr_q <= play_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      tog_q      <= tog_d;
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      dac_data_q <= dac_data_d;
      dac_clk_q  <= dac_clk_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  assign dac_data_o = dac_data_q;
  assign dac_clk_o  = dac_clk_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign level_o    = level_q;
  assign underrun_o = underrun_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_cfs_dac_player.sv
// Bench for cfs_dac_player: writes push expected samples into a queue; a monitor pops
// and compares on every rising dac_clk_o. An empty queue at a rising edge means the
// reference expects an underrun sample.
module tb_cfs_dac_player;

  localparam int unsigned DATA_W     = 14;
  localparam int unsigned DEPTH_LOG2 = 10;
  localparam int unsigned DIV_W      = 16;
  localparam int          MID        = 8192;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [DATA_W-1:0]   wr_data = '0;
  logic                wr_tog = 1'b0;
  logic                play_en = 1'b0;
  logic                loop_m = 1'b0;
  logic                clr = 1'b0;
  logic [DIV_W-1:0]    div = '0;
  logic [DATA_W-1:0]   dac_data;
  logic                dac_clk, full, empty, underrun, overflow;
  logic [DEPTH_LOG2:0] level;

  cfs_dac_player dut (
    .clk_i(clk), .rst_i(rst), .wr_data_i(wr_data), .wr_tog_i(wr_tog),
    .play_en_i(play_en), .loop_i(loop_m), .clr_i(clr), .div_i(div),
    .dac_data_o(dac_data), .dac_clk_o(dac_clk), .full_o(full), .empty_o(empty),
    .level_o(level), .underrun_o(underrun), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rises = 0;
  int last_rise_cyc = -1;
  int exp_period = 0;
  int last_out = MID;
  int exp_q[$];
  bit prev_dclk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one expected sample per DAC latch edge.
  always @(negedge clk) begin
    int e;
    if (!rst && dac_clk && !prev_dclk) begin
      rises++;
      if (exp_period != 0 && last_rise_cyc >= 0) chk("rise_period", cyc - last_rise_cyc, exp_period);
      last_rise_cyc = cyc;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dac_sample", int'(dac_data), e);
      end else begin
`ifdef CFS_DAC_UNDERRUN_MIDSCALE_EN
        e = MID;
`else
        e = last_out;
`endif
        chk("underrun_sample", int'(dac_data), e);
        chk("underrun_flag", int'(underrun), 1);
      end
      last_out = e;
    end
    prev_dclk = dac_clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d, input bit expect_play);
    wr_data = DATA_W'(d);
    wr_tog  = ~wr_tog;
    if (expect_play) exp_q.push_back(d);
    step();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_q.delete();
    last_out = MID;
  endtask

  task automatic wait_rises(input int n, input int budget);
    int base = rises;
    for (int i = 0; i < budget && (rises - base) < n; i++) step();
    chk("rises_reached", int'((rises - base) >= n), 1);
  endtask

  task automatic start_play(input int d);
    div = DIV_W'(d);
    exp_period = ((d == 0) ? 1 : d) + 1;
    last_rise_cyc = -1;
    play_en = 1'b1;
  endtask

  initial begin
    int n, d, k, r0;
    int vals[$];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_dac", int'(dac_data), MID);
    chk("rst_dclk", int'(dac_clk), 0);
    chk("rst_flags", int'({underrun, overflow}), 0);

    // Three writes, playback off: stored but nothing played.
    wr(100, 1); wr(200, 1); wr(300, 1);
    chk("wr3_level", int'(level), 3);
    chk("wr3_empty", int'(empty), 0);
    repeat (10) step();
    chk("idle_rises", rises, 0);
    chk("idle_dac", int'(dac_data), MID);

    // FIFO playback with div 3: latency, clock phase, then an underrun tick.
    loop_m = 1'b0;
    start_play(3);
    step(); step();
    chk("pre_first_dac", int'(dac_data), MID);
    step();
    chk("first_dac", int'(dac_data), 100);
    chk("first_dclk_lo", int'(dac_clk), 0);
    step();
    chk("dclk_lo_c1", int'(dac_clk), 0);
    step();
    chk("dclk_hi_c2", int'(dac_clk), 1);
    wait_rises(3, 100);
    wait_rises(1, 20);
    chk("underrun_set", int'(underrun), 1);
    chk("drain_level", int'(level), 0);
    play_en = 1'b0;
    step();

    // Randomised FIFO runs.
    for (int it = 0; it < 3; it++) begin
      do_clr();
      chk("clr_underrun", int'(underrun), 0);
      n = $urandom_range(24, 8);
      for (int i = 0; i < n; i++) wr($urandom_range(16383, 0), 1);
      chk("rnd_level", int'(level), n);
      d = $urandom_range(4, 0);
      start_play(d);
      wait_rises(n, n * 8 + 20);
      repeat ($urandom_range(12, 2)) step();
      play_en = 1'b0;
      step();
      chk("rnd_drained", int'(level), 0);
      chk("rnd_empty", int'(empty), 1);
    end

    // Fill to capacity, overflow, then a write coinciding with the first pop.
    do_clr();
    for (int i = 0; i < 1024; i++) wr($urandom_range(16383, 0), 1);
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(level), 1024);
    chk("fill_ovf", int'(overflow), 0);
    wr(5, 0);
    chk("drop_ovf", int'(overflow), 1);
    chk("drop_level", int'(level), 1024);
    chk("drop_full", int'(full), 1);
    start_play(1);
    step(); step();
    wr($urandom_range(16383, 0), 1);
    chk("coinc_level", int'(level), 1024);
    chk("coinc_full", int'(full), 1);
    wait_rises(1025, 3000);
    repeat (4) step();
    chk("full_drained", int'(level), 0);
    chk("ovf_sticky", int'(overflow), 1);
    play_en = 1'b0;
    step();

    // Loop mode 7,9 with flags still set, then clear mid-run with a strobe edge.
    exp_q.delete();
    loop_m = 1'b1;
    wr(7, 0); wr(9, 0);
    for (int i = 0; i < 32; i++) begin exp_q.push_back(7); exp_q.push_back(9); end
    start_play(1);
    wait_rises(20, 200);
    chk("loop_level", int'(level), 2);
    r0 = rises;
    wr_tog = ~wr_tog;
    do_clr();
    chk("clr_dac", int'(dac_data), MID);
    chk("clr_level", int'(level), 0);
    chk("clr_dclk", int'(dac_clk), 0);
    chk("clr_flags", int'({underrun, overflow}), 0);
    repeat (6) step();
    chk("clr_no_write", int'(level), 0);
    chk("clr_no_activity", rises - r0, 0);
    play_en = 1'b0;
    step();

    // Randomised loop runs, including a single entry.
    for (k = 1; k <= 3; k++) begin
      do_clr();
      vals.delete();
      for (int i = 0; i < k; i++) begin
        vals.push_back($urandom_range(16383, 0));
        wr(vals[i], 0);
      end
      for (int i = 0; i < 16 * k; i++) exp_q.push_back(vals[i % k]);
      start_play($urandom_range(3, 0));
      wait_rises(3 * k + 2, 200);
      chk("rloop_level", int'(level), k);
      chk("rloop_underrun", int'(underrun), 0);
      play_en = 1'b0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
